// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//   Baud timing generator for the UART TX/RX paths. Produces single-cycle
//   enable ticks in the system clock domain rather than a divided clock:
//   an oversample tick, a mid-bit sample tick and an end-of-bit tick.
//   The divisor is loadable at run time, and the bit phase can be restarted
//   by the RX start-bit detector.
//
//   Optional feature: define BAUD_FRAC_EN to build a fractional divisor
//   accumulator. When it is enabled, a carry out of the accumulator stretches
//   the next oversample period by one cycle. Without the macro, frac_i is
//   ignored and every oversample period is exactly div_eff cycles.
//
// Parameters
//   CNT_W    width of the integer divisor and of the cycle counter
//   OVS      oversample ticks per bit (even, >= 2)
//   FRAC_W   width of the fractional divisor
//   DEF_DIV  divisor loaded at reset
//
// Ports
//   clk_i       in   system clock, rising edge
//   rst_i       in   synchronous reset, active high
//   en_i        in   run enable; counters hold while low
//   cfg_we_i    in   load div_i/frac_i and restart counting
//   div_i       in   integer divisor (0 behaves as 1)
//   frac_i      in   fractional divisor, units of 1/2^FRAC_W
//   resync_i    in   restart the bit phase
//   ovs_tick_o  out  1-cycle pulse at baud*OVS
//   mid_tick_o  out  1-cycle pulse at mid-bit
//   bit_tick_o  out  1-cycle pulse at end of bit
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CNT_W   = 32,
    parameter int OVS     = 16,
    parameter int FRAC_W  = 4,
    parameter int DEF_DIV = 27
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              cfg_we_i,
    input  logic [CNT_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              resync_i,
    output logic              ovs_tick_o,
    output logic              mid_tick_o,
    output logic              bit_tick_o
);

    localparam int PH_W = $clog2(OVS);
    localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVS - 1);

    logic [CNT_W-1:0] r_div_q;
    logic [CNT_W-1:0] r_cnt;
    logic [PH_W-1:0]  r_phase;
    logic             r_ovs;
    logic             r_mid;
    logic             r_bit;

    logic [CNT_W-1:0] w_div_eff;
    logic             w_wrap;

    // Divisor 0 is treated as 1 so the counter always terminates.
    assign w_div_eff = (r_div_q == '0) ? CNT_W'(1) : r_div_q;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_frac_q;
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_q};

    // A pending carry lengthens the period to div_eff+1. Comparing against
    // div_eff (instead of computing div_eff+1) keeps the compare inside
    // CNT_W bits even for the all-ones divisor.
    assign w_wrap = r_carry ? (r_cnt == w_div_eff)
                            : (r_cnt == w_div_eff - CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frac_q <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
        end else if (cfg_we_i) begin
            r_frac_q <= frac_i;
            r_acc    <= '0;
            r_carry  <= 1'b0;
        end else if (resync_i) begin
            r_acc    <= '0;
            r_carry  <= 1'b0;
        end else if (en_i && w_wrap) begin
            // The carry produced at this tick applies to the next period.
            r_acc    <= w_acc_sum[FRAC_W-1:0];
            r_carry  <= w_acc_sum[FRAC_W];
        end
    end
`else
    logic w_unused_frac;
    assign w_unused_frac = ^frac_i;

    assign w_wrap = (r_cnt == w_div_eff - CNT_W'(1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_q <= CNT_W'(DEF_DIV);
            r_cnt   <= '0;
            r_phase <= '0;
            r_ovs   <= 1'b0;
            r_mid   <= 1'b0;
            r_bit   <= 1'b0;
        end else if (cfg_we_i) begin
            r_div_q <= div_i;
            r_cnt   <= '0;
            r_phase <= '0;
            r_ovs   <= 1'b0;
            r_mid   <= 1'b0;
            r_bit   <= 1'b0;
        end else if (resync_i) begin
            r_cnt   <= '0;
            r_phase <= '0;
            r_ovs   <= 1'b0;
            r_mid   <= 1'b0;
            r_bit   <= 1'b0;
        end else if (en_i) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                // Explicit wrap so a non-power-of-two OVS also works.
                r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + PH_W'(1);
                r_ovs   <= 1'b1;
                r_mid   <= (r_phase == MID_PH);
                r_bit   <= (r_phase == LAST_PH);
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_ovs   <= 1'b0;
                r_mid   <= 1'b0;
                r_bit   <= 1'b0;
            end
        end else begin
            r_ovs   <= 1'b0;
            r_mid   <= 1'b0;
            r_bit   <= 1'b0;
        end
    end

    assign ovs_tick_o = r_ovs;
    assign mid_tick_o = r_mid;
    assign bit_tick_o = r_bit;

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

    localparam int CNT_W   = 32;
    localparam int OVS     = 16;
    localparam int FRAC_W  = 4;
    localparam int DEF_DIV = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_we;
    logic              resync;
    logic [CNT_W-1:0]  div;
    logic [FRAC_W-1:0] frac;
    logic              ovs;
    logic              mid;
    logic              bitt;

    baud_tick_gen #(
        .CNT_W   (CNT_W),
        .OVS     (OVS),
        .FRAC_W  (FRAC_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .cfg_we_i   (cfg_we),
        .div_i      (div),
        .frac_i     (frac),
        .resync_i   (resync),
        .ovs_tick_o (ovs),
        .mid_tick_o (mid),
        .bit_tick_o (bitt)
    );

    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_pass = 0;
    longint cyc    = 0;
    bit     started = 1'b0;
    bit     exp_ovs, exp_mid, exp_bit;

    // Model state: divisor, fraction, enabled cycles in the current period,
    // and number of ovs ticks since the last restart.
    longint m_div, m_frac, m_elapsed, m_n;

    longint q_ovs[$];
    longint q_mid[$];
    longint q_bit[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint qat(input longint q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Tick m carries when m*frac/2^FRAC_W crosses an integer.
    function automatic longint carry_at(input longint m);
        if (m < 1) return 0;
        return ((m * m_frac) >> FRAC_W) - (((m - 1) * m_frac) >> FRAC_W);
    endfunction

    function automatic longint period_of(input longint n);
        longint d;
        d = (m_div < 1) ? 1 : m_div;
        return d + carry_at(n - 1);
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        exp_ovs = 1'b0;
        exp_mid = 1'b0;
        exp_bit = 1'b0;
        if (rst) begin
            m_div = DEF_DIV; m_frac = 0; m_elapsed = 0; m_n = 0;
        end else if (cfg_we) begin
            m_div = longint'(div);
`ifdef BAUD_FRAC_EN
            m_frac = longint'(frac);
`else
            m_frac = 0;
`endif
            m_elapsed = 0; m_n = 0;
        end else if (resync) begin
            m_elapsed = 0; m_n = 0;
        end else if (en) begin
            m_elapsed++;
            if (m_elapsed == period_of(m_n + 1)) begin
                m_elapsed = 0;
                m_n++;
                exp_ovs = 1'b1;
                exp_mid = ((m_n % OVS) == OVS / 2);
                exp_bit = ((m_n % OVS) == 0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("ovs_tick", longint'(ovs),  longint'(exp_ovs));
            chk("mid_tick", longint'(mid),  longint'(exp_mid));
            chk("bit_tick", longint'(bitt), longint'(exp_bit));
            if (ovs)  q_ovs.push_back(cyc);
            if (mid)  q_mid.push_back(cyc);
            if (bitt) q_bit.push_back(cyc);
        end
    end

    task automatic clear_q();
        q_ovs.delete();
        q_mid.delete();
        q_bit.delete();
    endtask

    // Called at a negedge; returns the cycle number of the load edge.
    task automatic load(input longint d, input longint f, output longint l);
        clear_q();
        cfg_we = 1'b1;
        div    = d[CNT_W-1:0];
        frac   = f[FRAC_W-1:0];
        l      = cyc + 1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        longint t0, l, r;
        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; resync = 1'b0;
        div = '0; frac = '0;
        repeat (3) @(negedge clk);
        chk("reset_ovs", longint'(ovs),  0);
        chk("reset_mid", longint'(mid),  0);
        chk("reset_bit", longint'(bitt), 0);

        // Default divisor after reset release
        clear_q();
        rst = 1'b0;
        t0  = cyc;
        repeat (900) @(negedge clk);
        chk("def_first_ovs",   qat(q_ovs, 0) - t0, 27);
        chk("def_ovs_spacing", qat(q_ovs, 1) - qat(q_ovs, 0), 27);
        chk("def_first_bit",   qat(q_bit, 0) - t0, 432);
        chk("def_bit_spacing", qat(q_bit, 1) - qat(q_bit, 0), 432);
        chk("def_mid_after_bit", qat(q_mid, 1) - qat(q_bit, 0), 216);

        // Divisor load in the middle of a count
        load(3, 0, l);
        repeat (20) @(negedge clk);
        chk("load3_first",   qat(q_ovs, 0) - l, 3);
        chk("load3_spacing", qat(q_ovs, 1) - qat(q_ovs, 0), 3);

        // Divisor 0 and 1: tick on every enabled cycle
        for (int d = 0; d < 2; d++) begin
            load(d, 0, l);
            repeat (40) @(negedge clk);
            chk("div01_first",   qat(q_ovs, 0) - l, 1);
            chk("div01_count",   q_ovs.size(), 40);
            chk("div01_bit_gap", qat(q_bit, 1) - qat(q_bit, 0), 16);
        end

        // Enable low for 10 cycles inside a period
        load(5, 0, l);
        while (cyc < l + 7) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_first",   qat(q_ovs, 0) - l, 5);
        chk("hold_spacing", qat(q_ovs, 1) - qat(q_ovs, 0), 15);
        chk("hold_resume",  qat(q_ovs, 2) - qat(q_ovs, 1), 5);

        // Resync while phase is 9
        load(4, 0, l);
        while (cyc < l + 37) @(negedge clk);
        clear_q();
        resync = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        resync = 1'b0;
        repeat (110) @(negedge clk);
        chk("resync_ovs", qat(q_ovs, 0) - r, 4);
        chk("resync_mid", qat(q_mid, 0) - r, 32);
        chk("resync_bit", qat(q_bit, 0) - r, 64);

        // Fractional divisor 4 + 8/16
        load(4, 8, l);
        repeat (170) @(negedge clk);
`ifdef BAUD_FRAC_EN
        chk("frac_p3",   qat(q_ovs, 2) - qat(q_ovs, 1), 5);
        chk("frac_p4",   qat(q_ovs, 3) - qat(q_ovs, 2), 4);
        chk("frac_span", qat(q_ovs, 33) - qat(q_ovs, 1), 144);
`else
        chk("frac_p3",   qat(q_ovs, 2) - qat(q_ovs, 1), 4);
        chk("frac_p4",   qat(q_ovs, 3) - qat(q_ovs, 2), 4);
        chk("frac_span", qat(q_ovs, 33) - qat(q_ovs, 1), 128);
`endif

        // cfg_we and resync together behave as cfg_we
        clear_q();
        cfg_we = 1'b1; resync = 1'b1; div = 6;
        l = cyc + 1;
        @(negedge clk);
        cfg_we = 1'b0; resync = 1'b0;
        repeat (8) @(negedge clk);
        chk("cfg_resync_first", qat(q_ovs, 0) - l, 6);

        // Reset in the middle of a period drops the pending tick
        clear_q();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        repeat (30) @(negedge clk);
        chk("rst_mid_first", qat(q_ovs, 0) - t0, 27);
        chk("rst_mid_count", q_ovs.size(), 1);

        // Largest divisor: no tick in a short window
        load(64'h0000_0000_FFFF_FFFF, 0, l);
        repeat (40) @(negedge clk);
        chk("maxdiv_count", q_ovs.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
